// File: rtl/ysyx_25040105_sram_resp.sv
// On-chip word memory answering AXI4-Lite-style AR/R/AW/W/B requests with a
// fixed, programmable wait between request acceptance and response.
module ysyx_25040105_sram_resp #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W  = $clog2(DEPTH);
  localparam logic [31:0] SPAN   = 32'(DEPTH) << 2;
  localparam logic [3:0]  LAT    = 4'(LATENCY);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t   r_state, r_next;
  logic [31:0] r_addr_q;
  logic [3:0]  r_cnt;
  logic        ar_hs, r_hs, r_enter_resp;
  logic [31:0] r_addr_eff, r_off;
  logic        r_in_range;
  logic [IDX_W-1:0] r_idx;

  w_state_t   w_state, w_next;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q, w_cnt;
  logic        aw_hs, w_hs, b_hs, w_both, w_commit;
  logic [31:0] aw_eff, wd_eff, w_off;
  logic [3:0]  ws_eff;
  logic        w_in_range;
  logic [IDX_W-1:0] w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (LAT == 4'd0) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_cnt <= 4'd1) r_next = R_RESP;
      R_RESP:  if (r_hs) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = !rst && (r_state == R_IDLE);
    rvalid  = !rst && (r_state == R_RESP);
  end

  // With zero latency the sample happens on the handshake edge itself, so the
  // live address is used instead of the not-yet-latched copy.
  assign ar_hs        = arvalid && arready;
  assign r_hs         = rvalid && rready;
  assign r_enter_resp = (r_next == R_RESP) && (r_state != R_RESP);
  assign r_addr_eff   = (r_state == R_IDLE) ? araddr : r_addr_q;
  assign r_off        = r_addr_eff - BASE_ADDR;
  assign r_in_range   = r_off < SPAN;
  assign r_idx        = r_off[IDX_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q <= '0;
      r_cnt    <= '0;
      rdata    <= '0;
      rresp    <= OKAY;
    end else begin
      if (ar_hs) begin
        r_addr_q <= araddr;
        r_cnt    <= LAT;
      end else if (r_state == R_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_enter_resp) begin
        rdata <= r_in_range ? mem[r_idx] : 32'h0;
        rresp <= r_in_range ? OKAY : SLVERR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (w_both) w_next = (LAT == 4'd0) ? W_RESP : W_WAIT;
      W_WAIT:  if (w_cnt <= 4'd1) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = !rst && (w_state == W_IDLE) && !aw_got;
    wready  = !rst && (w_state == W_IDLE) && !w_got;
    bvalid  = !rst && (w_state == W_RESP);
  end

  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign b_hs       = bvalid && bready;
  assign w_both     = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign w_commit   = (w_next == W_RESP) && (w_state != W_RESP);
  assign aw_eff     = aw_got ? aw_addr_q : awaddr;
  assign wd_eff     = w_got ? w_data_q : wdata;
  assign ws_eff     = w_got ? w_strb_q : wstrb;
  assign w_off      = aw_eff - BASE_ADDR;
  assign w_in_range = w_off < SPAN;
  assign w_idx      = w_off[IDX_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_cnt     <= '0;
      bresp     <= OKAY;
    end else begin
      if (aw_hs) begin
        aw_got    <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (w_both) w_cnt <= LAT;
      else if (w_state == W_WAIT) w_cnt <= w_cnt - 4'd1;
      if (w_commit) bresp <= w_in_range ? OKAY : SLVERR;
      if (b_hs) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  // Storage is never reset; a same-edge read in the block above sees the old word.
  always_ff @(posedge clk) begin
    if (w_commit && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (ws_eff[i]) mem[w_idx][8*i +: 8] <= wd_eff[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/ysyx_25040105_sram_resp.md
Name: ysyx_25040105_sram_resp

Overview:
- Memory responder (slave end) for the core's load/store and fetch path; replaces DPI vaddr_read/vaddr_write with a synthesizable on-chip word memory.
- Speaks an AXI4-Lite-style valid/ready protocol on five independent channels: AR, R, AW, W and B.
- Has a programmable response latency, so IFU/LSU handshake logic can be exercised against a non-zero-wait memory.

Parameters:
- DEPTH, 1024, memory size in 32-bit words (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, wait cycles between request acceptance and response valid (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- araddr  input  32  read byte address.
- arvalid  input  1  read request valid.
- arready  output  1  read request accept.
- rdata  output  32  read data.
- rresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
- rvalid  output  1  read response valid.
- rready  input  1  read response accept.
- awaddr  input  32  write byte address.
- awvalid  input  1  write address valid.
- awready  output  1  write address accept.
- wdata  input  32  write data.
- wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i].
- wvalid  input  1  write data valid.
- wready  output  1  write data accept.
- bresp  output  2  write response, same encoding as rresp.
- bvalid  output  1  write response valid.
- bready  input  1  write response accept.

Behaviour:
- Reset (asynchronous): both FSMs go to idle.
  - arready, awready, wready, rvalid and bvalid are 0 while rst=1.
  - rdata, rresp and bresp reset to 0.
  - Memory contents are not reset.
  - Reset asserted mid-transaction aborts it: no write is committed and no response is issued.
- Address decode:
  - off = addr - BASE_ADDR; word index = off[31:2]; addr[1:0] is ignored.
  - off >= DEPTH*4, including underflow wrap below BASE_ADDR, is out of range: resp = SLVERR, rdata = 0, write suppressed.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP.
  - R_IDLE: arready=1. On arvalid&&arready, latch the address and load the counter with LATENCY.
  - LATENCY=0: go directly to R_RESP on the next cycle.
  - R_WAIT: decrement the counter each cycle; on reaching 0, enter R_RESP.
  - rdata/rresp are sampled from memory on the entry edge into R_RESP.
  - R_RESP: rvalid=1; rdata/rresp held stable until rready. On rvalid&&rready, return to R_IDLE. No new AR is accepted that cycle (arready is 1 only in R_IDLE).
  - Latency from AR handshake to rvalid is LATENCY+1 cycles.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP.
  - W_IDLE:
    - awready=1 until AW is captured; wready=1 until W is captured.
    - AW and W may handshake in either order or in the same cycle.
    - When both are captured, load the counter with LATENCY and go to W_WAIT (W_RESP if LATENCY=0).
  - W_WAIT: count down as for reads.
  - The memory write commits on the entry edge into W_RESP, byte-masked by wstrb. wstrb=0 is legal: no bytes change, OKAY is returned.
  - W_RESP: bvalid=1 with bresp held until bready; then return to W_IDLE and clear the capture flags.
- Read/write independence:
  - The channels are fully independent; a read and a write may be in flight at the same time.
  - If a read samples the same word on the same edge that a write commits, the read returns the old data (read-before-write).
- Backpressure: rready/bready held low keeps the response stable indefinitely; no further request of that type is accepted.

Test Plan:
1. Reset, then write 32'hDEADBEEF to 32'h8000_0010 with wstrb=4'hF, LATENCY=1; read the same address -> bvalid 2 cycles after the AW/W handshake with bresp=00; rvalid 2 cycles after AR with rdata=32'hDEADBEEF, rresp=00.
2. Byte strobes: word initialized to 32'h11223344, write wdata=32'hAABBCCDD with wstrb=4'b0101, then read -> rdata=32'h11BB33DD.
3. Split handshake: AW at cycle 0, W at cycle 3 -> awready drops after cycle 0, wready stays 1 until cycle 3, bvalid rises at cycle 5 (LATENCY=1).
4. Out of range: read 32'h8000_1000 and write 32'h7FFF_FFFC with DEPTH=1024 -> rresp=10 with rdata=0; bresp=10; memory unchanged on re-read.
5. Backpressure and collision:
   - Hold rready=0 for 5 cycles -> rvalid and rdata stable, arready=0 throughout.
   - Same-edge read/write of one word -> read returns the pre-write value; the next read returns the new value.
6. Asynchronous reset asserted while the write FSM is in W_WAIT -> bvalid=0 immediately and the target word is unchanged; with LATENCY=0, AR to rvalid is 1 cycle.
